// File: rtl/aud_i2s_tx_if.sv
// Byte stream from the SD reader into the I2S output stage.
// Valid/ready handshake: a byte moves when ByteValid && ByteReady.
interface aud_i2s_tx_if;
    logic [7:0] ByteData;
    logic       ByteValid;
    logic       ByteReady;

    modport master (output ByteData, output ByteValid, input ByteReady);
    modport slave  (input ByteData, input ByteValid, output ByteReady);
endinterface

// File: rtl/aud_i2s_tx.sv
// Audio output stage: packs SD reader bytes into 16-bit stereo frames,
// buffers them in a register FIFO and serialises them as Philips I2S.
module aud_i2s_tx #(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = 5
) (
    input  logic             MasterCLK,
    input  logic             Reset,
    aud_i2s_tx_if.slave      byte_if,
    input  logic             Enable,
    output logic             I2S_CLK,
    output logic             I2S_WS,
    output logic             I2S_DATA,
    output logic [LVL_W-1:0] FifoLevel,
    output logic             Underrun
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [1:0]       bcnt;
    logic [7:0]       b0, b1, b2;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       slot;
    logic [31:0]      sh;

    logic accept, push, pop, div_tc, slot_tick, wrap;
    logic [4:0] slot_nxt;

    assign byte_if.ByteReady = (FifoLevel != LVL_W'(FIFO_DEPTH));

    always_comb begin
        accept    = byte_if.ByteValid && byte_if.ByteReady;
        push      = accept && (bcnt == 2'd3);
        div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
        slot_tick = Enable && div_tc && I2S_CLK;
        wrap      = slot_tick && (slot == 5'd31);
        pop       = wrap && (FifoLevel != '0);
        slot_nxt  = slot + 5'd1;
    end

    // Storage has no reset; pointers and level define what is valid.
    always_ff @(posedge MasterCLK) begin
        if (push)
            mem[wr_ptr] <= {b1, b0, byte_if.ByteData, b2};
    end

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            bcnt      <= '0;
            b0        <= '0;
            b1        <= '0;
            b2        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            FifoLevel <= '0;
            Underrun  <= 1'b0;
            div_cnt   <= '0;
            I2S_CLK   <= 1'b0;
            I2S_WS    <= 1'b0;
            I2S_DATA  <= 1'b0;
            slot      <= 5'd31;
            sh        <= '0;
        end else begin
            if (accept) begin
                bcnt <= bcnt + 2'd1;
                case (bcnt)
                    2'd0:    b0 <= byte_if.ByteData;
                    2'd1:    b1 <= byte_if.ByteData;
                    2'd2:    b2 <= byte_if.ByteData;
                    default: ;
                endcase
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   FifoLevel <= FifoLevel + LVL_W'(1);
                2'b01:   FifoLevel <= FifoLevel - LVL_W'(1);
                default: ;
            endcase
            Underrun <= wrap && (FifoLevel == '0);

            if (!Enable) begin
                div_cnt  <= '0;
                I2S_CLK  <= 1'b0;
                I2S_WS   <= 1'b0;
                I2S_DATA <= 1'b0;
                slot     <= 5'd31;
                sh       <= '0;
            end else begin
                div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
                if (div_tc)
                    I2S_CLK <= ~I2S_CLK;
                if (slot_tick) begin
                    // sh[31] carries the bit one slot late, so slot 0 emits
                    // the previous frame's right LSB before the reload.
                    slot     <= slot_nxt;
                    I2S_WS   <= slot_nxt[4];
                    I2S_DATA <= sh[31];
                    if (wrap)
                        sh <= pop ? mem[rd_ptr] : '0;
                    else
                        sh <= {sh[30:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed self-checking bench for aud_i2s_tx with CLK_DIV=2, FIFO_DEPTH=16.
module tb_aud_i2s_tx;
    logic       MasterCLK = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       I2S_CLK, I2S_WS, I2S_DATA, Underrun;
    logic [4:0] FifoLevel;
    int         errors = 0;
    int         checks = 0;

    aud_i2s_tx_if bif ();

    aud_i2s_tx #(.CLK_DIV(2), .FIFO_DEPTH(16), .LVL_W(5)) dut (
        .MasterCLK (MasterCLK),
        .Reset     (Reset),
        .byte_if   (bif.slave),
        .Enable    (Enable),
        .I2S_CLK   (I2S_CLK),
        .I2S_WS    (I2S_WS),
        .I2S_DATA  (I2S_DATA),
        .FifoLevel (FifoLevel),
        .Underrun  (Underrun)
    );

    always #5 MasterCLK = ~MasterCLK;

    task automatic tick;
        @(posedge MasterCLK);
        #1;
    endtask

    function automatic logic [7:0] bval(input int i, input int k);
        return 8'(i * 16 + k);
    endfunction

    // left = {b1,b0}, right = {b3,b2}
    function automatic logic [31:0] fw(input int i);
        return {bval(i, 1), bval(i, 0), bval(i, 3), bval(i, 2)};
    endfunction

    task automatic push_byte(input logic [7:0] d);
        bif.ByteData  = d;
        bif.ByteValid = 1'b1;
        tick();
        bif.ByteValid = 1'b0;
    endtask

    task automatic push_frame(input int i);
        for (int k = 0; k < 4; k++) push_byte(bval(i, k));
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        Enable = 1'b0;
        bif.ByteValid = 1'b0;
        bif.ByteData = '0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_slot(output int n);
        logic prev;
        n = -1;
        for (int i = 1; i <= 16; i++) begin
            prev = I2S_CLK;
            tick();
            if (prev && !I2S_CLK) begin
                n = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL slot_timeout: got no I2S_CLK fall within 16 cycles, required one");
    endtask

    // Entered at slot 0; returns at slot 0 of the following frame.
    task automatic capture_frame(output logic [31:0] w, output logic [31:0] wsv);
        int n;
        w = '0;
        wsv = '0;
        for (int s = 1; s <= 31; s++) begin
            wait_slot(n);
            w[32 - s] = I2S_DATA;
            wsv[s] = I2S_WS;
        end
        wait_slot(n);
        w[0] = I2S_DATA;
        wsv[0] = I2S_WS;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({I2S_CLK, I2S_WS, I2S_DATA, Underrun, bif.ByteReady} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: clk/ws/data/und/rdy=%b required 00001",
                     {I2S_CLK, I2S_WS, I2S_DATA, Underrun, bif.ByteReady});
        end
        checks++;
        if (FifoLevel !== 5'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d required 0", FifoLevel);
        end
        repeat (5) tick();
        checks++;
        if ({I2S_CLK, I2S_WS, I2S_DATA, Underrun, bif.ByteReady, FifoLevel} !== {5'b00001, 5'd0}) begin
            errors++;
            $display("FAIL idle_outputs: got %b required 0000100000",
                     {I2S_CLK, I2S_WS, I2S_DATA, Underrun, bif.ByteReady, FifoLevel});
        end
    endtask

    task automatic test_frame;
        int n;
        logic [31:0] w, wsv;
        do_reset();
        push_byte(8'h34);
        push_byte(8'h12);
        push_byte(8'h78);
        push_byte(8'h56);
        checks++;
        if (FifoLevel !== 5'd1) begin
            errors++;
            $display("FAIL frame_level_push: got %0d required 1", FifoLevel);
        end
        Enable = 1'b1;
        wait_slot(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL first_fall: got cycle %0d required 4", n);
        end
        checks++;
        if ({I2S_WS, I2S_DATA, Underrun, FifoLevel} !== {3'b000, 5'd0}) begin
            errors++;
            $display("FAIL frame_slot0: ws/data/und/level=%b required 00000000",
                     {I2S_WS, I2S_DATA, Underrun, FifoLevel});
        end
        capture_frame(w, wsv);
        checks++;
        if (w !== 32'h1234_5678) begin
            errors++;
            $display("FAIL frame_data: got %h required 12345678", w);
        end
        checks++;
        if (wsv !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL frame_ws: got %h required ffff0000", wsv);
        end
        checks++;
        if (Underrun !== 1'b1) begin
            errors++;
            $display("FAIL frame_next_underrun: got %b required 1", Underrun);
        end
        Enable = 1'b0;
    endtask

    task automatic test_underrun;
        int und, ones, wst, clkt;
        logic pws, pclk;
        do_reset();
        Enable = 1'b1;
        und = 0; ones = 0; wst = 0; clkt = 0;
        pws = I2S_WS;
        pclk = I2S_CLK;
        for (int c = 0; c < 258; c++) begin
            tick();
            if (Underrun) und++;
            if (I2S_DATA) ones++;
            if (I2S_WS != pws) wst++;
            if (I2S_CLK != pclk) clkt++;
            pws = I2S_WS;
            pclk = I2S_CLK;
        end
        checks++;
        if (und !== 2) begin
            errors++;
            $display("FAIL underrun_pulses: got %0d required 2", und);
        end
        checks++;
        if (ones !== 0) begin
            errors++;
            $display("FAIL underrun_data: got %0d high cycles required 0", ones);
        end
        checks++;
        if (wst !== 3) begin
            errors++;
            $display("FAIL underrun_ws_toggles: got %0d required 3", wst);
        end
        checks++;
        if (clkt !== 129) begin
            errors++;
            $display("FAIL underrun_clk_toggles: got %0d required 129", clkt);
        end
        Enable = 1'b0;
    endtask

    task automatic test_full;
        int n;
        logic [31:0] w, wsv;
        do_reset();
        for (int i = 0; i < 16; i++) push_frame(i);
        checks++;
        if ({FifoLevel, bif.ByteReady} !== {5'd16, 1'b0}) begin
            errors++;
            $display("FAIL full_level: level=%0d rdy=%b required 16 0", FifoLevel, bif.ByteReady);
        end
        push_byte(8'hEE);
        checks++;
        if (FifoLevel !== 5'd16) begin
            errors++;
            $display("FAIL full_ignore: got %0d required 16", FifoLevel);
        end
        Enable = 1'b1;
        wait_slot(n);
        checks++;
        if ({FifoLevel, bif.ByteReady} !== {5'd15, 1'b1}) begin
            errors++;
            $display("FAIL full_first_pop: level=%0d rdy=%b required 15 1", FifoLevel, bif.ByteReady);
        end
        capture_frame(w, wsv);
        checks++;
        if (w !== fw(0)) begin
            errors++;
            $display("FAIL full_head: got %h required %h", w, fw(0));
        end
        Enable = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) push_byte(bval(7, k));
        checks++;
        if (FifoLevel !== 5'd14) begin
            errors++;
            $display("FAIL full_bytecnt_3: got %0d required 14", FifoLevel);
        end
        push_byte(bval(7, 3));
        checks++;
        if (FifoLevel !== 5'd15) begin
            errors++;
            $display("FAIL full_bytecnt_4: got %0d required 15", FifoLevel);
        end
    endtask

    task automatic test_back_to_back;
        logic prev;
        logic [31:0] w, wsv;
        do_reset();
        for (int i = 0; i < 5; i++) push_frame(i);
        for (int k = 0; k < 3; k++) push_byte(bval(5, k));
        Enable = 1'b1;
        repeat (3) tick();
        bif.ByteData = bval(5, 3);
        bif.ByteValid = 1'b1;
        prev = I2S_CLK;
        tick();
        bif.ByteValid = 1'b0;
        checks++;
        if ({prev, I2S_CLK, FifoLevel} !== {2'b10, 5'd5}) begin
            errors++;
            $display("FAIL b2b_level: clk %b->%b level=%0d required 1->0 level 5", prev, I2S_CLK, FifoLevel);
        end
        for (int i = 0; i < 6; i++) begin
            capture_frame(w, wsv);
            checks++;
            if (w !== fw(i)) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h required %h", i, w, fw(i));
            end
        end
        checks++;
        if ({Underrun, FifoLevel} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL b2b_drain: und=%b level=%0d required 1 0", Underrun, FifoLevel);
        end
        Enable = 1'b0;
    endtask

    task automatic test_disable;
        int n;
        logic [31:0] w, wsv;
        do_reset();
        push_frame(8);
        push_frame(9);
        push_byte(bval(10, 0));
        push_byte(bval(10, 1));
        Enable = 1'b1;
        wait_slot(n);
        for (int s = 1; s <= 20; s++) wait_slot(n);
        checks++;
        if ({I2S_WS, FifoLevel} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL dis_slot20: ws=%b level=%0d required 1 1", I2S_WS, FifoLevel);
        end
        Enable = 1'b0;
        tick();
        checks++;
        if ({I2S_CLK, I2S_WS, I2S_DATA, FifoLevel} !== {3'b000, 5'd1}) begin
            errors++;
            $display("FAIL dis_outputs: clk/ws/data/level=%b required 00000001",
                     {I2S_CLK, I2S_WS, I2S_DATA, FifoLevel});
        end
        repeat (3) tick();
        Enable = 1'b1;
        wait_slot(n);
        checks++;
        if ({n == 4, I2S_WS, I2S_DATA, FifoLevel} !== {3'b100, 5'd0}) begin
            errors++;
            $display("FAIL dis_restart: cycles=%0d ws=%b data=%b level=%0d required 4 0 0 0",
                     n, I2S_WS, I2S_DATA, FifoLevel);
        end
        capture_frame(w, wsv);
        checks++;
        if (w !== fw(9)) begin
            errors++;
            $display("FAIL dis_next_frame: got %h required %h", w, fw(9));
        end
        Enable = 1'b0;
        tick();
        push_byte(bval(10, 2));
        push_byte(bval(10, 3));
        checks++;
        if (FifoLevel !== 5'd1) begin
            errors++;
            $display("FAIL dis_bytecnt: got %0d required 1", FifoLevel);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({FifoLevel, bif.ByteReady} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_midstream: level=%0d rdy=%b required 0 1", FifoLevel, bif.ByteReady);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Enable = 1'b0;
        bif.ByteValid = 1'b0;
        bif.ByteData = '0;
        test_reset();
        test_frame();
        test_underrun();
        test_full();
        test_back_to_back();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aud_i2s_tx.md
Name: aud_i2s_tx

Overview:
- Audio output stage downstream of the SD byte reader in the AudVid peripheral.
- Takes the raw audio byte stream the SD reader produces and packs it into 16-bit stereo frames.
- Buffers the frames in a FIFO and serialises them as standard Philips I2S on I2S_CLK/I2S_WS/I2S_DATA.
- All I2S timing is derived from MasterCLK by division.

Parameters:
- CLK_DIV, 8: MasterCLK cycles per I2S_CLK half-period (I2S_CLK period = 2*CLK_DIV cycles). Legal range ≥ 2.
- FIFO_DEPTH, 16: number of 32-bit stereo frames buffered. Power of two, ≥ 2.
- LVL_W, 5: width of FifoLevel; must equal clog2(FIFO_DEPTH)+1.

Ports:
- MasterCLK  in  1  sole clock; everything is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- ByteData  in  8  audio byte from the SD reader.
- ByteValid  in  1  ByteData is valid this cycle.
- ByteReady  out  1  block can accept a byte; transfer occurs when ByteValid && ByteReady.
- Enable  in  1  run the I2S serialiser.
- I2S_CLK  out  1  bit clock.
- I2S_WS  out  1  word select; 0 = left, 1 = right.
- I2S_DATA  out  1  serial data, MSB first.
- FifoLevel  out  LVL_W  frames currently stored.
- Underrun  out  1  one-cycle pulse when a frame slot starts with the FIFO empty.

Behaviour:
- Clocking and reset:
  - One clock, MasterCLK; reset is synchronous and active-high on Reset.
  - Reset values: ByteReady=1, I2S_CLK=0, I2S_WS=0, I2S_DATA=0, FifoLevel=0, Underrun=0.
  - Reset also clears the byte counter, FIFO pointers and divider, and sets the slot counter to 31.
- Byte packing:
  - A 2-bit byte counter steps 0→1→2→3→0 on each accepted byte.
  - Frame layout: left = {b1,b0}, right = {b3,b2} (little-endian 16-bit, left first). Frame word = {left,right}, 32 bits.
  - The fourth accepted byte pushes the completed frame in that same cycle; FifoLevel increments on the next edge.
  - ByteReady = (FifoLevel != FIFO_DEPTH), combinational from registered level. Because only this path pushes, a push can never overflow.
  - Byte intake is independent of Enable, so the FIFO can be prefilled while stopped.
- Divider and I2S_CLK:
  - Counter runs 0..CLK_DIV-1 while Enable=1; I2S_CLK toggles on terminal count.
  - Enable=0: counter=0, I2S_CLK=0.
  - First rising edge of I2S_CLK comes CLK_DIV cycles after Enable rises; first falling edge at 2*CLK_DIV.
- Slot sequencing:
  - Slot counter (5 bits, 0..31) advances, with wrap, in the cycle I2S_CLK goes 1→0. I2S_WS and I2S_DATA update in that same cycle.
  - Entering slot 0:
    - FIFO non-empty: pop a frame into the shift register; FifoLevel decrements.
    - FIFO empty: load 32'h0 and pulse Underrun for one cycle.
  - I2S_WS = 0 for slots 0..15, 1 for slots 16..31.
  - I2S_DATA (one-bit I2S delay):
    - Slot 0: right bit0 of the previous frame (0 after Reset or Enable rise).
    - Slots 1..16: left bits 15..0.
    - Slots 17..31: right bits 15..1.
- Simultaneous push and pop in one cycle: FifoLevel unchanged, both operations take effect.
- Enable deassert mid-frame:
  - Next cycle: I2S_CLK=0, I2S_WS=0, I2S_DATA=0, slot counter=31.
  - The partially sent frame is discarded, not replayed. FIFO contents and the byte counter are kept.
- Reset mid-frame or mid-packing: any partial byte group and all FIFO contents are discarded.
- FIFO storage is plain registers or inferred RAM. Read data must be available in the pop cycle (registered-output RAM is not allowed).

Test Plan:
- Reset then idle, Enable=0 → all outputs at reset values, ByteReady=1, FifoLevel=0.
- Push bytes 34,12,78,56 (hex), Enable=1, CLK_DIV=2 → first falling edge at cycle 4. Slot 0: WS=0, DATA=0. Slots 1..16 carry 16'h1234 MSB first. WS=1 from slot 16. Slots 17..31 plus next slot 0 carry 16'h5678. FifoLevel 1→0 at first pop.
- Enable=1 with an empty FIFO → Underrun pulses once per 32 slots, I2S_DATA stays 0, WS still toggles every 16 slots.
- Push 4*FIFO_DEPTH bytes with Enable=0 → FifoLevel=16, ByteReady=0. A further ByteValid is ignored. Enable → first pop drops level to 15 and ByteReady returns to 1.
- Push byte 4 of a frame in the same cycle as a slot-0 pop at level 5 → level stays 5, frame order preserved.
- Deassert Enable at slot 20, reassert → outputs zero immediately. The next frame starts at slot 0 from the FIFO head. Byte counter unaffected; Reset pulse mid-stream → FifoLevel=0 on next cycle.
